// File: rtl/rc5_job_arbiter_if.sv
// Requester-side request/response handshake bundle for rc5_job_arbiter.
// Requester i uses bit i of each 2-bit field and slice i of the packed operand fields.
interface rc5_job_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [9:0]  req_rounds;
    logic [63:0] req_data;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_rounds, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_rounds, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/rc5_job_arbiter.sv
// Shares one RC5 core between two requesters: round-robin grant, start pulse,
// result capture, per-requester response handshake and watchdog abort.
module rc5_job_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned MAX_ROUNDS     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    rc5_job_arbiter_if.slave        bus,
    output logic                    core_rst,
    output logic                    core_encrypt,
    output logic                    core_decrypt,
    output logic [4:0]              core_rounds,
    output logic [31:0]             core_din,
    input  logic [31:0]             core_dout,
    input  logic                    core_done,
    output logic                    busy,
    output logic [7:0]              err_count
);

    localparam int unsigned    WdW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StAbort, StResp} state_e;

    state_e          state_q, state_d;
    logic            last_grant_q;
    logic            owner_q;
    logic            op_q;
    logic [4:0]      rounds_q;
    logic [31:0]     data_q;
    logic [31:0]     result_q;
    logic            err_q;
    logic [WdW-1:0]  wd_q;
    logic [7:0]      err_count_q;

    logic            grant;
    logic            accept;
    logic            reject;
    logic            resp_hs;
    logic            sel_op;
    logic [4:0]      sel_rounds;
    logic [31:0]     sel_data;

    function automatic logic [7:0] sat_inc(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Grant the sole requester, or on a tie the one that was not served last.
    always_comb begin
        grant = bus.req_valid[1];
        if (bus.req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end
        sel_op     = bus.req_op[grant];
        sel_rounds = grant ? bus.req_rounds[9:5] : bus.req_rounds[4:0];
        sel_data   = grant ? bus.req_data[63:32] : bus.req_data[31:0];
        reject     = 32'(sel_rounds) > MAX_ROUNDS;
        accept     = (state_q == StIdle) && (bus.req_valid != 2'b00);
        resp_hs    = bus.resp_ready[owner_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = reject ? StResp : StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // done takes priority over an expiring watchdog
                if (core_done) begin
                    state_d = StResp;
                end else if (wd_q == WdLimit) begin
                    state_d = StAbort;
                end
            end
            StAbort: state_d = StResp;
            StResp: begin
                if (resp_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready  = (rst && accept) ? (2'b01 << grant) : 2'b00;
        bus.resp_valid = (state_q == StResp) ? (2'b01 << owner_q) : 2'b00;
        bus.resp_data  = result_q;
        bus.resp_err   = err_q;
        core_encrypt   = (state_q == StIssue) && !op_q;
        core_decrypt   = (state_q == StIssue) && op_q;
        core_rst       = rst && (state_q != StAbort);
        core_rounds    = rounds_q;
        core_din       = data_q;
        busy           = (state_q != StIdle);
        err_count      = err_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= 1'b0;
            rounds_q     <= '0;
            data_q       <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            err_count_q  <= '0;
        end else begin
            if (accept) begin
                owner_q  <= grant;
                op_q     <= sel_op;
                rounds_q <= sel_rounds;
                data_q   <= sel_data;
                err_q    <= reject;
                result_q <= '0;
                if (reject) begin
                    err_count_q <= sat_inc(err_count_q);
                end
            end
            unique case (state_q)
                StIssue: wd_q <= '0;
                StWait: begin
                    wd_q <= wd_q + WdW'(1);
                    if (core_done) begin
                        result_q <= core_dout;
                        err_q    <= 1'b0;
                    end
                end
                StAbort: begin
                    result_q    <= '0;
                    err_q       <= 1'b1;
                    err_count_q <= sat_inc(err_count_q);
                end
                StResp: begin
                    if (resp_hs) begin
                        last_grant_q <= owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rc5_job_arbiter.md
Name: rc5_job_arbiter

Overview:
- Shares one RC5 algo core (encrypt/decrypt, num_rounds, d_in, d_out, done) between two requesters.
- Owns the whole transaction for the core:
  - round-robin arbitration and request validation
  - single-cycle start pulse to the core, with operands held stable for the full operation
  - result capture and per-requester response handshake
  - watchdog abort that resets the core if done never arrives.

Parameters:
- TIMEOUT_CYCLES, 40, WAIT-state cycles before abort; must exceed MAX_ROUNDS+3.
- MAX_ROUNDS, 16, largest legal round count; larger requests are rejected.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  bit i: requester i has a job.
- req_ready  out  2  bit i: job i accepted this cycle.
- req_op  in  2  bit i: 0=encrypt, 1=decrypt.
- req_rounds  in  10  requester i rounds in [5i+4:5i].
- req_data  in  64  requester i block in [32i+31:32i].
- resp_valid  out  2  bit i: result pending for requester i.
- resp_ready  in  2  bit i: requester i consumes result.
- resp_data  out  32  result for the requester whose resp_valid is set.
- resp_err  out  1  qualifies resp_data: 1=rejected or timed out.
- core_rst  out  1  active-low reset to the core; equals rst AND NOT abort.
- core_encrypt  out  1  start-encrypt pulse.
- core_decrypt  out  1  start-decrypt pulse.
- core_rounds  out  5  round count to the core.
- core_din  out  32  input block to the core.
- core_dout  in  32  core result.
- core_done  in  1  core completion strobe.
- busy  out  1  high in every state except IDLE.
- err_count  out  8  saturating count of rejections plus timeouts.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, last_grant=1 (requester 0 wins first tie).
  - All outputs 0 except core_rst, which follows rst.
  - Latched op/rounds/data and the watchdog counter are cleared.
  - Reset mid-operation abandons the job with no response.
- FSM states: IDLE, ISSUE, WAIT, ABORT, RESP.
- IDLE:
  - If any req_valid is set, pick the grant g:
    - only one valid: that requester.
    - both valid: the requester that is not last_grant.
  - req_ready[g]=1 combinationally that cycle; the accept is cycle T.
  - Latch op, rounds and data; owner=g.
  - If rounds>MAX_ROUNDS: go to RESP with err=1, result=0, err_count++.
  - Otherwise go to ISSUE.
- ISSUE (T+1):
  - Exactly one of core_encrypt/core_decrypt=1, for one cycle only.
  - Then go to WAIT with the watchdog counter cleared.
- core_rounds and core_din are driven from the latched registers continuously from ISSUE until return to IDLE. The core samples d_in one cycle after the start pulse, so these values must not change in between.
- WAIT:
  - Counter increments each cycle.
  - If core_done=1: capture core_dout, err=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: go to ABORT.
  - If core_done and the limit coincide, done wins.
- ABORT:
  - Drive core_rst=0 for exactly one cycle; err_count++.
  - Go to RESP with err=1, result=0.
- RESP:
  - resp_valid[owner]=1; resp_data and resp_err stay stable until resp_ready[owner]=1.
  - On resp_ready[owner]=1: last_grant=owner, go to IDLE.
  - resp_ready of the non-owner is ignored.
  - No new request is accepted until IDLE, giving one outstanding job at a time.
- Latency:
  - core_done arrives at T+3+R for R rounds, or T+2 for R=0.
  - resp_valid rises one cycle after core_done: T+4+R, or T+3 for R=0.
  - Minimum return to IDLE: the cycle after resp_ready.
- Counter rules:
  - err_count saturates at 255 and never wraps.
  - The watchdog counter is clog2(TIMEOUT_CYCLES) wide and never wraps within WAIT.
- A requester may drop req_valid before acceptance without penalty.
- While stalled, req_* must stay stable until req_ready is seen.

Test Plan:
- Encrypt, requester 0, rounds=12, data=0x12345678 accepted at T:
  - core_encrypt high only at T+1, core_din=0x12345678 held.
  - resp_valid[0] at T+16, resp_data equals core_dout at core_done, resp_err=0.
- Both requesters valid every cycle from reset, resp_ready held 1:
  - grants alternate 0,1,0,1.
  - no start pulse overlaps a busy core.
- Rounds=0 decrypt from requester 1:
  - core_done at T+2, resp_valid[1] at T+3.
  - rounds=17 is rejected at T+1 with resp_err=1, resp_data=0, err_count=1, and no core_encrypt/core_decrypt pulse.
- Stub core that never asserts done:
  - core_rst low for exactly one cycle after 40 WAIT cycles.
  - resp_err=1, err_count increments; the next job then completes normally.
- resp_ready held low for 10 cycles:
  - resp_valid/resp_data stable throughout.
  - req_ready stays 0 for the other requester until release.
- rst asserted low during WAIT (round 5):
  - all outputs clear immediately (async), no response emitted.
  - after release, requester 0 wins the first tie.
